gauge_capture: RTL and testbench
================================

Name: gauge_capture

Overview:
Reads the 8-LED power-gauge bar that sweeps during aiming and converts the player's fire-button press into a captured shot-power level for the game controller. It synchronises and debounces the raw button, samples the thermometer-coded bar, decodes it to a 0..8 level with a pattern-error flag, and presents the result on a valid/ack handshake. It sits between the gauge sweep output and the turn/shot FSM.

Parameters:
DB_CYCLES, 4, consecutive synchronised-sample cycles required to confirm a press or a release; legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on rising edge
nrst  input  1  reset, asynchronous and active-low; one clock, all flops cleared when nrst=0
arm  input  1  level; game FSM requests a shot capture while high
btn  input  1  raw fire button, active-high, asynchronous to clk
bar  input  8  gauge LED pattern, bit 7 = first LED lit, fills toward bit 0
shot_ack  input  1  consumer accepts the held result
armed  output  1  high while in ARMED, waiting for a press
shot_valid  output  1  high while a captured result is held
shot_level  output  4  decoded level 0..8, stable while shot_valid
shot_err  output  1  captured bar was not a legal thermometer pattern

Behaviour:
- Reset: state=IDLE; armed=0, shot_valid=0, shot_level=0, shot_err=0; both sync flops, bar_q and debounce counter cleared. Reset mid-operation aborts any capture or held result immediately, with no handshake.
- btn passes through two flops to give btn_s, 2-cycle latency. bar is registered every cycle into bar_q.
- Debounce counter is 8 bits. In REL it counts consecutive btn_s=0 cycles; in ARMED it counts consecutive btn_s=1 cycles. It clears on any opposite sample and on every state change. The condition is met at an edge where the counter equals DB_CYCLES-1 and the sample has the required value.
- Decode of bar_q: level = number of consecutive 1s starting at bit 7. err=1 if any bit below that run is 1.
- Decode examples: 8'h00 -> 0/0; 8'hE0 -> 3/0; 8'hFF -> 8/0; 8'hA0 -> 1/1; 8'h01 -> 0/1.
- IDLE: go to REL when arm=1.
- REL: waits for the button to be released. Go to IDLE if arm=0, which has priority. Go to ARMED when the release condition is met. This means a button already held at arm time is never captured.
- ARMED: armed=1. Go to IDLE if arm=0, which has priority over a same-cycle press. When the press condition is met, register the decoded level/err of bar_q and go to HOLD.
- HOLD: shot_valid=1; shot_level and shot_err are frozen; arm and btn are ignored. On shot_ack=1 go to IDLE, and shot_valid drops the next cycle. shot_level and shot_err keep their last values in IDLE.
- shot_ack outside HOLD is ignored.
- Latency: let edge 0 be the first edge at which btn=1 is sampled, held stable, with state ARMED. shot_valid is high after edge DB_CYCLES+1. The captured value is the decode of bar as sampled at edge DB_CYCLES.
- A bounce (btn_s=0 for one cycle) during ARMED restarts the count.
- With DB_CYCLES=1, one high sample of btn_s suffices.
- Back-to-back: after ack the block returns to IDLE. If arm is still high it goes to REL on the next edge, so a new capture needs a fresh release and press.

Test Plan:
- Reset: nrst=0 with arm=1, btn=1 -> all outputs 0, state IDLE; release reset with arm=1, btn=1 held -> stays in REL, armed=0, no capture.
- Clean press, DB_CYCLES=4: arm=1, btn low 4+ cycles -> armed=1; bar=8'hF0, btn=1 from edge 0 -> shot_valid=1 after edge 5, shot_level=4, shot_err=0; ack -> shot_valid=0 next cycle.
- Bounce: in ARMED, btn 1,1,1,0,1,1,1,1 -> no capture at 3 highs; valid only after 4 consecutive synchronised highs. Bar changes 8'hC0 -> 8'hFF during the press -> level taken from the bar sampled at the capture-minus-one edge.
- Decode sweep: capture with bar = 8'h00, 8'h80, 8'hFE, 8'hFF, 8'hA0, 8'h01 -> levels 0/1/7/8/1/0, err 0/0/0/0/1/1.
- Abort and hold: arm drops in the same cycle the press condition is met -> IDLE, no valid. In HOLD, toggle arm and btn -> result unchanged until ack. nrst pulse in HOLD -> shot_valid=0 immediately.
- Re-arm: ack while arm=1 and btn still held -> REL, no second capture until release and a new press.

Source files
------------

// File: rtl/gauge_capture.sv
// gauge_capture
//   Converts a fire-button press into a captured shot-power level. The raw
//   button is synchronised and debounced, the thermometer-coded gauge bar is
//   registered and decoded to a 0..8 level with a pattern-error flag, and the
//   captured result is held on a valid/ack handshake.
//
// Ports
//   clk         system clock, rising edge
//   nrst        asynchronous active-low reset
//   arm         game FSM requests a capture while high
//   btn         raw fire button, active-high, asynchronous to clk
//   bar[7:0]    gauge LEDs, bit 7 lights first and the fill moves toward bit 0
//   shot_ack    consumer accepts the held result
//   armed       high while waiting for a press
//   shot_valid  high while a captured result is held
//   shot_level  captured level 0..8, stable while shot_valid
//   shot_err    captured bar was not a legal thermometer pattern
module gauge_capture #(
  parameter int unsigned DB_CYCLES = 4  // legal range 1..255
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       arm,
  input  logic       btn,
  input  logic [7:0] bar,
  input  logic       shot_ack,
  output logic       armed,
  output logic       shot_valid,
  output logic [3:0] shot_level,
  output logic       shot_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REL   = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // The debounce count is met when the counter already holds DB_CYCLES-1
  // and the current sample still has the wanted value.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic       btn_meta_q;
  logic       btn_s_q;
  logic [7:0] bar_q;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic [3:0] level_q, level_d;
  logic       err_q, err_d;

  logic [3:0] dec_level;
  logic       dec_err;
  logic       in_run;

  // Thermometer decode: count the unbroken run of ones from bit 7; any one
  // found after the run has ended marks the pattern as illegal.
  always_comb begin
    dec_level = 4'd0;
    dec_err   = 1'b0;
    in_run    = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (bar_q[i]) begin
        if (in_run) dec_level = dec_level + 4'd1;
        else        dec_err   = 1'b1;
      end else begin
        in_run = 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        db_cnt_d = 8'd0;
        if (arm) state_d = S_REL;
      end

      // Wait for a confirmed release so a button already held at arm time
      // can never produce a shot.
      S_REL: begin
        if (!arm) begin
          state_d  = S_IDLE;
          db_cnt_d = 8'd0;
        end else if (!btn_s_q) begin
          if (db_cnt_q == DB_LAST) begin
            state_d  = S_ARMED;
            db_cnt_d = 8'd0;
          end else begin
            db_cnt_d = db_cnt_q + 8'd1;
          end
        end else begin
          db_cnt_d = 8'd0;
        end
      end

      // Dropping arm wins over a press confirmed in the same cycle.
      S_ARMED: begin
        if (!arm) begin
          state_d  = S_IDLE;
          db_cnt_d = 8'd0;
        end else if (btn_s_q) begin
          if (db_cnt_q == DB_LAST) begin
            state_d  = S_HOLD;
            db_cnt_d = 8'd0;
            level_d  = dec_level;
            err_d    = dec_err;
          end else begin
            db_cnt_d = db_cnt_q + 8'd1;
          end
        end else begin
          db_cnt_d = 8'd0;
        end
      end

      S_HOLD: begin
        db_cnt_d = 8'd0;
        if (shot_ack) state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        db_cnt_d = 8'd0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, matching real register behaviour.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      bar_q      <= 8'h00;
      db_cnt_q   <= 8'd0;
      level_q    <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Two-flop synchroniser: btn is asynchronous to clk.
      btn_meta_q <= btn;
      btn_s_q    <= btn_meta_q;
      bar_q      <= bar;
      db_cnt_q   <= db_cnt_d;
      level_q    <= level_d;
      err_q      <= err_d;
    end
  end

  assign armed      = (state_q == S_ARMED);
  assign shot_valid = (state_q == S_HOLD);
  assign shot_level = level_q;
  assign shot_err   = err_q;

endmodule

// File: tb/tb_gauge_capture.sv
// tb_gauge_capture
//   Directed self-checking bench for gauge_capture with DB_CYCLES=4. Inputs
//   are driven and outputs sampled on the falling clock edge.
module tb_gauge_capture;

  logic       clk;
  logic       nrst;
  logic       arm;
  logic       btn;
  logic [7:0] bar;
  logic       shot_ack;
  logic       armed;
  logic       shot_valid;
  logic [3:0] shot_level;
  logic       shot_err;

  int n_vec;
  int n_err;

  gauge_capture #(.DB_CYCLES(4)) u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .arm        (arm),
    .btn        (btn),
    .bar        (bar),
    .shot_ack   (shot_ack),
    .armed      (armed),
    .shot_valid (shot_valid),
    .shot_level (shot_level),
    .shot_err   (shot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Release the button and wait (bounded) for ARMED.
  task automatic release_to_armed(input string tag);
    int n;
    btn = 1'b0;
    n   = 0;
    while (!armed && n < 20) begin
      tick();
      n++;
    end
    check(tag, armed, 1);
  endtask

  // From ARMED: press with bar held, expect valid after edge 5, then ack.
  task automatic press_capture(input string tag, input logic [7:0] b,
                               input logic [3:0] lvl, input logic err);
    bar = b;
    btn = 1'b1;
    repeat (5) tick();
    check({tag, "_early"}, shot_valid, 0);
    tick();
    check({tag, "_valid"}, shot_valid, 1);
    check({tag, "_level"}, shot_level, lvl);
    check({tag, "_err"}, shot_err, err);
    shot_ack = 1'b1;
    tick();
    shot_ack = 1'b0;
    check({tag, "_ackdrop"}, shot_valid, 0);
    check({tag, "_keep"}, shot_level, lvl);
  endtask

  logic [7:0] sweep_bar [6] = '{8'h00, 8'h80, 8'hFE, 8'hFF, 8'hA0, 8'h01};
  logic [3:0] sweep_lvl [6] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd1, 4'd0};
  logic       sweep_err [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] bnc_btn   = 8'b1111_0111;  // bit k = btn for edge k
  logic [7:0] bnc_bar   [10];

  initial begin
    n_vec    = 0;
    n_err    = 0;
    nrst     = 1'b0;
    arm      = 1'b1;
    btn      = 1'b1;
    bar      = 8'hFF;
    shot_ack = 1'b0;

    // Reset with arm and btn asserted.
    repeat (3) tick();
    check("rst_armed", armed, 0);
    check("rst_valid", shot_valid, 0);
    check("rst_level", shot_level, 0);
    check("rst_err", shot_err, 0);

    // Held button at arm time: stays in REL.
    nrst = 1'b1;
    repeat (10) tick();
    check("held_armed", armed, 0);
    check("held_valid", shot_valid, 0);

    // Release: 2 sync edges + 4 debounce edges.
    btn = 1'b0;
    repeat (5) tick();
    check("rel_edge5", armed, 0);
    tick();
    check("rel_edge6", armed, 1);

    // Ack outside HOLD is ignored.
    shot_ack = 1'b1;
    tick();
    shot_ack = 1'b0;
    check("stray_ack_armed", armed, 1);
    check("stray_ack_valid", shot_valid, 0);

    // Clean press.
    press_capture("clean", 8'hF0, 4'd4, 1'b0);
    release_to_armed("clean_rel");

    // Bounce: btn 1,1,1,0,1,1,1,1 then held. Bar C0 to edge 7, FF at
    // edge 8, 00 at edge 9; capture happens at edge 9 from bar of edge 8.
    for (int k = 0; k < 10; k++) bnc_bar[k] = (k < 8) ? 8'hC0 : ((k == 8) ? 8'hFF : 8'h00);
    for (int k = 0; k < 10; k++) begin
      btn = (k < 8) ? bnc_btn[k] : 1'b1;
      bar = bnc_bar[k];
      tick();
      if (k == 5) check("bnc_3high", shot_valid, 0);
      if (k == 8) check("bnc_edge8", shot_valid, 0);
    end
    check("bnc_valid", shot_valid, 1);
    check("bnc_level", shot_level, 8);
    check("bnc_err", shot_err, 0);
    shot_ack = 1'b1;
    tick();
    shot_ack = 1'b0;
    check("bnc_ack", shot_valid, 0);
    release_to_armed("bnc_rel");

    // Decode sweep.
    for (int i = 0; i < 6; i++) begin
      press_capture($sformatf("sweep%0d", i), sweep_bar[i], sweep_lvl[i], sweep_err[i]);
      release_to_armed($sformatf("sweep%0d_rel", i));
    end

    // Abort: arm drops on the edge the press would be confirmed.
    bar = 8'h80;
    btn = 1'b1;
    repeat (5) tick();
    arm = 1'b0;
    tick();
    check("abort_valid", shot_valid, 0);
    check("abort_armed", armed, 0);
    repeat (8) tick();
    check("abort_later", shot_valid, 0);
    check("abort_level", shot_level, 0);
    check("abort_err", shot_err, 1);
    arm = 1'b1;
    repeat (10) tick();
    check("abort_rel", armed, 0);
    release_to_armed("abort_rearm");

    // HOLD ignores arm, btn and bar.
    bar = 8'hE0;
    btn = 1'b1;
    repeat (6) tick();
    check("hold_valid", shot_valid, 1);
    check("hold_level", shot_level, 3);
    arm = 1'b0;
    btn = 1'b0;
    bar = 8'hFF;
    repeat (4) tick();
    arm = 1'b1;
    btn = 1'b1;
    repeat (3) tick();
    check("hold_still", shot_valid, 1);
    check("hold_level2", shot_level, 3);
    check("hold_err2", shot_err, 0);
    check("hold_armed", armed, 0);

    // Asynchronous reset in HOLD.
    #2 nrst = 1'b0;
    #1;
    check("areset_valid", shot_valid, 0);
    check("areset_level", shot_level, 0);
    check("areset_err", shot_err, 0);
    tick();
    nrst = 1'b1;
    repeat (6) tick();
    check("areset_rel", armed, 0);

    // Re-arm: ack with arm high and btn held gives no second capture.
    release_to_armed("rearm_rel");
    press_capture("rearm_cap", 8'hE0, 4'd3, 1'b0);
    repeat (12) tick();
    check("rearm_novalid", shot_valid, 0);
    check("rearm_noarmed", armed, 0);
    release_to_armed("rearm_rel2");
    press_capture("rearm_cap2", 8'hFF, 4'd8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
